// File: rtl/mem_access_unit.sv
// Memory stage: issues cache requests, stalls the pipeline on misses and registers MEM/WB results.
// Optional build macro MEM_STALL_CNT_EN adds a saturating stall_cycles counter output.
module mem_access_unit (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic        RegWr_in,
  input  logic        jal_in,
  input  logic        halt_in,
  input  logic [4:0]  wsel_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_in,
  input  logic [31:0] pcplusfour_in,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_stall,
`ifdef MEM_STALL_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        RegWr_out,
  output logic [4:0]  wsel_out,
  output logic [31:0] wdat_out,
  output logic        halt_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, HALTED} state_t;

  state_t      state_q, state_d;
  logic        buf_wen_q, buf_wen_d;
  logic        buf_regwr_q, buf_regwr_d;
  logic        buf_halt_q, buf_halt_d;
  logic [4:0]  buf_wsel_q, buf_wsel_d;
  logic [31:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_store_q, buf_store_d;
  logic        regwr_out_q, regwr_out_d;
  logic [4:0]  wsel_out_q, wsel_out_d;
  logic [31:0] wdat_out_q, wdat_out_d;
  logic        halt_out_q, halt_out_d;
  logic        memop;

  assign memop = dREN_in | dWEN_in;

  always_comb begin
    state_d     = state_q;
    buf_wen_d   = buf_wen_q;
    buf_regwr_d = buf_regwr_q;
    buf_halt_d  = buf_halt_q;
    buf_wsel_d  = buf_wsel_q;
    buf_addr_d  = buf_addr_q;
    buf_store_d = buf_store_q;
    regwr_out_d = 1'b0;
    wsel_out_d  = wsel_out_q;
    wdat_out_d  = wdat_out_q;
    halt_out_d  = halt_out_q;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    dmemaddr    = '0;
    dmemstore   = '0;
    mem_stall   = 1'b0;

    case (state_q)
      IDLE: begin
        // A simultaneous read and write request is treated as a store.
        dmemWEN   = dWEN_in;
        dmemREN   = dREN_in & ~dWEN_in;
        dmemaddr  = alu_in;
        dmemstore = store_in;
        if (memop) begin
          buf_wen_d   = dWEN_in;
          buf_regwr_d = RegWr_in;
          buf_halt_d  = halt_in;
          buf_wsel_d  = wsel_in;
          buf_addr_d  = alu_in;
          buf_store_d = store_in;
          if (dhit) begin
            regwr_out_d = RegWr_in & ~dWEN_in;
            if (!dWEN_in) begin
              wsel_out_d = wsel_in;
              wdat_out_d = dmemload;
            end
            if (halt_in) begin
              halt_out_d = 1'b1;
              state_d    = HALTED;
            end
          end else begin
            mem_stall = 1'b1;
            state_d   = ACCESS;
          end
        end else begin
          regwr_out_d = RegWr_in;
          wsel_out_d  = wsel_in;
          wdat_out_d  = jal_in ? pcplusfour_in : alu_in;
          if (halt_in) begin
            halt_out_d = 1'b1;
            state_d    = HALTED;
          end
        end
      end

      ACCESS: begin
        // Upstream inputs are ignored here; the buffered request is replayed until acknowledged.
        dmemWEN   = buf_wen_q;
        dmemREN   = ~buf_wen_q;
        dmemaddr  = buf_addr_q;
        dmemstore = buf_store_q;
        mem_stall = ~dhit;
        if (dhit) begin
          regwr_out_d = buf_regwr_q & ~buf_wen_q;
          if (!buf_wen_q) begin
            wsel_out_d = buf_wsel_q;
            wdat_out_d = dmemload;
          end
          if (buf_halt_q) begin
            halt_out_d = 1'b1;
            state_d    = HALTED;
          end else begin
            state_d = IDLE;
          end
        end
      end

      HALTED: begin
        halt_out_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      buf_wen_q   <= 1'b0;
      buf_regwr_q <= 1'b0;
      buf_halt_q  <= 1'b0;
      buf_wsel_q  <= '0;
      buf_addr_q  <= '0;
      buf_store_q <= '0;
      regwr_out_q <= 1'b0;
      wsel_out_q  <= '0;
      wdat_out_q  <= '0;
      halt_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_wen_q   <= buf_wen_d;
      buf_regwr_q <= buf_regwr_d;
      buf_halt_q  <= buf_halt_d;
      buf_wsel_q  <= buf_wsel_d;
      buf_addr_q  <= buf_addr_d;
      buf_store_q <= buf_store_d;
      regwr_out_q <= regwr_out_d;
      wsel_out_q  <= wsel_out_d;
      wdat_out_q  <= wdat_out_d;
      halt_out_q  <= halt_out_d;
    end
  end

  assign RegWr_out = regwr_out_q;
  assign wsel_out  = wsel_out_q;
  assign wdat_out  = wdat_out_q;
  assign halt_out  = halt_out_q;

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (mem_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, JAL, reset during a miss and halt behaviour.
module tb_mem_access_unit;

  logic        CLK;
  logic        nRST;
  logic        dREN_in, dWEN_in, RegWr_in, jal_in, halt_in;
  logic [4:0]  wsel_in;
  logic [31:0] alu_in, store_in, pcplusfour_in;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore;
  logic        RegWr_out, halt_out;
  logic [4:0]  wsel_out;
  logic [31:0] wdat_out;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int vectors = 0;
  int miscompares = 0;

  mem_access_unit dut (
    .CLK(CLK), .nRST(nRST),
    .dREN_in(dREN_in), .dWEN_in(dWEN_in), .RegWr_in(RegWr_in), .jal_in(jal_in),
    .halt_in(halt_in), .wsel_in(wsel_in), .alu_in(alu_in), .store_in(store_in),
    .pcplusfour_in(pcplusfour_in), .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall),
`ifdef MEM_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .RegWr_out(RegWr_out), .wsel_out(wsel_out), .wdat_out(wdat_out), .halt_out(halt_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    dREN_in = 0; dWEN_in = 0; RegWr_in = 0; jal_in = 0; halt_in = 0;
    wsel_in = 0; alu_in = 0; store_in = 0; pcplusfour_in = 0; dhit = 0; dmemload = 0;
  endtask

  initial begin
    nRST = 0;
    idle_inputs();
    tick(); tick();
    check("rst_regwr", {31'd0, RegWr_out}, 32'd0);
    check("rst_wsel", {27'd0, wsel_out}, 32'd0);
    check("rst_wdat", wdat_out, 32'd0);
    check("rst_halt", {31'd0, halt_out}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_ren", {31'd0, dmemREN}, 32'd0);
    nRST = 1;

    // JAL writeback uses PC+4
    jal_in = 1; RegWr_in = 1; wsel_in = 5'd31; pcplusfour_in = 32'h44; alu_in = 32'h99;
    #1 check("jal_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("jal_regwr", {31'd0, RegWr_out}, 32'd1);
    check("jal_wsel", {27'd0, wsel_out}, 32'd31);
    check("jal_wdat", wdat_out, 32'h44);

    // plain ALU result
    jal_in = 0; wsel_in = 5'd5; alu_in = 32'hCAFE;
    tick();
    check("alu_wsel", {27'd0, wsel_out}, 32'd5);
    check("alu_wdat", wdat_out, 32'hCAFE);

    // load missing for three cycles
    dREN_in = 1; RegWr_in = 1; wsel_in = 5'd8; alu_in = 32'h100; dhit = 0;
    #1;
    check("ld_ren0", {31'd0, dmemREN}, 32'd1);
    check("ld_addr0", dmemaddr, 32'h100);
    check("ld_stall0", {31'd0, mem_stall}, 32'd1);
    tick();
    check("ld_bubble1", {31'd0, RegWr_out}, 32'd0);
    dREN_in = 0; RegWr_in = 0; wsel_in = 5'd3; alu_in = 32'hFFF;
    #1;
    check("ld_addr1", dmemaddr, 32'h100);
    check("ld_ren1", {31'd0, dmemREN}, 32'd1);
    check("ld_stall1", {31'd0, mem_stall}, 32'd1);
    tick();
    check("ld_stall2", {31'd0, mem_stall}, 32'd1);
    tick();
    dhit = 1; dmemload = 32'hDEADBEEF;
    #1;
    check("ld_stall3", {31'd0, mem_stall}, 32'd0);
    check("ld_ren3", {31'd0, dmemREN}, 32'd1);
    tick();
    dhit = 0;
    check("ld_regwr", {31'd0, RegWr_out}, 32'd1);
    check("ld_wsel", {27'd0, wsel_out}, 32'd8);
    check("ld_wdat", wdat_out, 32'hDEADBEEF);
    #1 check("ld_ren_drop", {31'd0, dmemREN}, 32'd0);
`ifdef MEM_STALL_CNT_EN
    check("ld_stall_cnt", stall_cycles, 32'd3);
`endif

    // zero-wait store
    idle_inputs();
    dWEN_in = 1; RegWr_in = 1; alu_in = 32'h200; store_in = 32'h1234; dhit = 1;
    #1;
    check("st_wen", {31'd0, dmemWEN}, 32'd1);
    check("st_ren", {31'd0, dmemREN}, 32'd0);
    check("st_addr", dmemaddr, 32'h200);
    check("st_data", dmemstore, 32'h1234);
    check("st_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("st_regwr", {31'd0, RegWr_out}, 32'd0);

    // read and write together behave as a store
    dREN_in = 1;
    #1;
    check("rw_ren", {31'd0, dmemREN}, 32'd0);
    check("rw_wen", {31'd0, dmemWEN}, 32'd1);
    tick();
    check("rw_regwr", {31'd0, RegWr_out}, 32'd0);

    // zero-wait load
    idle_inputs();
    dREN_in = 1; RegWr_in = 1; wsel_in = 5'd9; alu_in = 32'h300; dhit = 1; dmemload = 32'h55;
    #1 check("zl_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("zl_regwr", {31'd0, RegWr_out}, 32'd1);
    check("zl_wsel", {27'd0, wsel_out}, 32'd9);
    check("zl_wdat", wdat_out, 32'h55);

    // reset abandons an outstanding miss
    dhit = 0; wsel_in = 5'd12;
    tick();
    idle_inputs();
    nRST = 0;
    tick();
    check("rs_ren", {31'd0, dmemREN}, 32'd0);
    check("rs_stall", {31'd0, mem_stall}, 32'd0);
    check("rs_regwr", {31'd0, RegWr_out}, 32'd0);
    check("rs_wsel", {27'd0, wsel_out}, 32'd0);
    check("rs_wdat", wdat_out, 32'd0);
    check("rs_halt", {31'd0, halt_out}, 32'd0);
    nRST = 1;

    // halt is sticky and blocks later requests
    halt_in = 1;
    tick();
    check("h_halt", {31'd0, halt_out}, 32'd1);
    halt_in = 0; dREN_in = 1; RegWr_in = 1; wsel_in = 5'd4; alu_in = 32'h400;
    #1;
    check("h_ren", {31'd0, dmemREN}, 32'd0);
    check("h_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check("h_regwr", {31'd0, RegWr_out}, 32'd0);
    check("h_sticky", {31'd0, halt_out}, 32'd1);
    tick();
    check("h_ren2", {31'd0, dmemREN}, 32'd0);
    check("h_sticky2", {31'd0, halt_out}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
